// File: rtl/gs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : gs_pkg                                                    |
// | Purpose  : Shared sizes, FSM state encoding and neighbour-mask bit   |
// |            positions for the 16-unknown banded Gauss-Seidel solver.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package gs_pkg;

  localparam int N_ROWS = 16;   // unknowns per system
  localparam int IDX_W  = 4;    // row / register index width
  localparam int X_W    = 32;   // x word width, signed 16.16
  localparam int B_W    = 16;   // b word width
  localparam int NB_W   = 6;    // neighbour-mask width

  // Neighbour-mask bit positions: which off-diagonal terms are in range
  localparam int NB_M1 = 0;     // x[i-1]
  localparam int NB_P1 = 1;     // x[i+1]
  localparam int NB_M2 = 2;     // x[i-2]
  localparam int NB_P2 = 3;     // x[i+2]
  localparam int NB_M3 = 4;     // x[i-3]
  localparam int NB_P3 = 5;     // x[i+3]

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ITER   = 3'd2,
    DRAIN  = 3'd3,
    OUTPUT = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/gs_nb_mask.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : gs_nb_mask                                                |
// | Purpose  : Combinational row index -> neighbour term-valid mask.     |
// |            A bit is set iff the neighbour index lies in 0..15.       |
// | Ports    : i_row_idx  row index i                                    |
// |            o_nb_mask  [0]i-1 [1]i+1 [2]i-2 [3]i+2 [4]i-3 [5]i+3      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module gs_nb_mask
  import gs_pkg::*;
(
  input  logic [IDX_W-1:0] i_row_idx,
  output logic [NB_W-1:0]  o_nb_mask
);

  always_comb begin
    o_nb_mask        = '0;
    o_nb_mask[NB_M1] = (i_row_idx >= IDX_W'(1));
    o_nb_mask[NB_M2] = (i_row_idx >= IDX_W'(2));
    o_nb_mask[NB_M3] = (i_row_idx >= IDX_W'(3));
    o_nb_mask[NB_P1] = (i_row_idx <= IDX_W'(N_ROWS - 2));
    o_nb_mask[NB_P2] = (i_row_idx <= IDX_W'(N_ROWS - 3));
    o_nb_mask[NB_P3] = (i_row_idx <= IDX_W'(N_ROWS - 4));
  end

endmodule
`default_nettype wire

// File: rtl/gs_sweep_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : gs_sweep_controller                                       |
// | Purpose  : Control sequencer for the 16-unknown banded Gauss-Seidel  |
// |            solver: b load, row issue, write-back timing, x[i-1]      |
// |            forwarding, per-sweep convergence check, solution output. |
// |            Holds no datapath storage.                                |
// | Ports    : clk, reset (async, active-high)                           |
// |            in_en            b-load strobe (16 contiguous beats)      |
// |            x_new/x_old      write-back value and prior stored value  |
// |            b_we/b_waddr     b register write                         |
// |            x_clr            zero all x registers                     |
// |            row_vld/row_idx/nb_mask/fwd_m1  row issue                 |
// |            x_we/x_waddr     x write-back                             |
// |            out_valid/out_idx  solution stream                        |
// |            iter_cnt/converged/load_err/busy  status                  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module gs_sweep_controller
  import gs_pkg::*;
#(
  parameter int          ITER_MAX = 50,
  parameter int          ITER_W   = 6,
  parameter logic [31:0] TOL      = 32'd16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_en,
  input  logic [X_W-1:0]    x_new,
  input  logic [X_W-1:0]    x_old,
  output logic              b_we,
  output logic [IDX_W-1:0]  b_waddr,
  output logic              x_clr,
  output logic              row_vld,
  output logic [IDX_W-1:0]  row_idx,
  output logic [NB_W-1:0]   nb_mask,
  output logic              fwd_m1,
  output logic              x_we,
  output logic [IDX_W-1:0]  x_waddr,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_idx,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              converged,
  output logic              load_err,
  output logic              busy
);

  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(N_ROWS - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_cnt;        // load_cnt in LOAD, r in ITER, beat in OUTPUT
  logic [IDX_W-1:0]   w_cnt_nxt;
  logic [ITER_W-1:0]  r_iter_cnt;
  logic [ITER_W-1:0]  w_iter_nxt;
  logic [ITER_W-1:0]  w_iter_inc;
  logic               r_converged;
  logic               w_conv_nxt;
  logic               r_x_we;
  logic [IDX_W-1:0]   r_x_waddr;
  logic               r_sweep_ok;
  logic               w_sweep_ok_fin;
  logic [NB_W-1:0]    w_mask;
  logic [X_W:0]       w_delta;
  logic [X_W:0]       w_abs;
  logic               w_pass;

  gs_nb_mask u_nb_mask (
    .i_row_idx (row_idx),
    .o_nb_mask (w_mask)
  );

  // 33-bit difference so that extreme operands cannot wrap into a small delta
  assign w_delta = {x_new[X_W-1], x_new} - {x_old[X_W-1], x_old};
  assign w_abs   = w_delta[X_W] ? (~w_delta + 1'b1) : w_delta;
  assign w_pass  = (w_abs < {1'b0, TOL});

  // Row 15's write-back lands in DRAIN, so fold it in before deciding
  assign w_sweep_ok_fin = r_sweep_ok & w_pass;
  assign w_iter_inc     = r_iter_cnt + ITER_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_iter_cnt  <= '0;
      r_converged <= 1'b0;
      r_x_we      <= 1'b0;
      r_x_waddr   <= '0;
      r_sweep_ok  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_iter_cnt  <= w_iter_nxt;
      r_converged <= w_conv_nxt;
      // Computation unit has one cycle of latency
      r_x_we      <= row_vld;
      r_x_waddr   <= row_idx;
      if (r_x_we) begin
        r_sweep_ok <= (r_x_waddr == '0) ? w_pass : (r_sweep_ok & w_pass);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_iter_nxt  = r_iter_cnt;
    w_conv_nxt  = r_converged;
    b_we        = 1'b0;
    b_waddr     = '0;
    x_clr       = 1'b0;
    row_vld     = 1'b0;
    row_idx     = '0;
    fwd_m1      = 1'b0;
    out_valid   = 1'b0;
    out_idx     = '0;
    load_err    = 1'b0;

    case (r_state)
      IDLE: begin
        b_we  = in_en;
        x_clr = in_en;
        if (in_en) begin
          w_state_nxt = LOAD;
          w_cnt_nxt   = IDX_W'(1);
          w_iter_nxt  = '0;
          w_conv_nxt  = 1'b0;
        end
      end
      LOAD: begin
        b_we    = in_en;
        b_waddr = r_cnt;
        if (!in_en) begin
          load_err    = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_LAST) begin
          w_state_nxt = ITER;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + IDX_W'(1);
        end
      end
      ITER: begin
        row_vld = 1'b1;
        row_idx = r_cnt;
        // x[i-1] is still in flight when row i issues; x[i-2] is already stored
        fwd_m1  = (r_cnt != '0);
        if (r_cnt == c_LAST) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + IDX_W'(1);
        end
      end
      DRAIN: begin
        w_iter_nxt = w_iter_inc;
        w_cnt_nxt  = '0;
        if (w_sweep_ok_fin) begin
          w_conv_nxt  = 1'b1;
          w_state_nxt = OUTPUT;
        end else if (w_iter_inc == ITER_W'(ITER_MAX)) begin
          w_state_nxt = OUTPUT;
        end else begin
          w_state_nxt = ITER;
        end
      end
      OUTPUT: begin
        out_valid = 1'b1;
        out_idx   = r_cnt;
        if (r_cnt == c_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + IDX_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Lookup is driven by row_idx at all times; only present it while issuing
  assign nb_mask   = row_vld ? w_mask : '0;
  assign x_we      = r_x_we;
  assign x_waddr   = r_x_waddr;
  assign iter_cnt  = r_iter_cnt;
  assign converged = r_converged;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gs_sweep_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_gs_sweep_controller                                    |
// | Purpose  : Scoreboard bench for gs_sweep_controller. Stimulus tasks  |
// |            push timestamped expected beats; a negedge monitor pops   |
// |            and compares whenever the DUT presents a beat.            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_gs_sweep_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_en;
  logic [31:0] x_new, x_old;
  logic        b_we;
  logic [3:0]  b_waddr;
  logic        x_clr;
  logic        row_vld;
  logic [3:0]  row_idx;
  logic [5:0]  nb_mask;
  logic        fwd_m1;
  logic        x_we;
  logic [3:0]  x_waddr;
  logic        out_valid;
  logic [3:0]  out_idx;
  logic [5:0]  iter_cnt;
  logic        converged;
  logic        load_err;
  logic        busy;

  gs_sweep_controller #(.ITER_MAX(50), .ITER_W(6), .TOL(32'd16)) dut (
    .clk(clk), .reset(reset), .in_en(in_en), .x_new(x_new), .x_old(x_old),
    .b_we(b_we), .b_waddr(b_waddr), .x_clr(x_clr), .row_vld(row_vld),
    .row_idx(row_idx), .nb_mask(nb_mask), .fwd_m1(fwd_m1), .x_we(x_we),
    .x_waddr(x_waddr), .out_valid(out_valid), .out_idx(out_idx),
    .iter_cnt(iter_cnt), .converged(converged), .load_err(load_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Hand-derived boundary masks, bit order [5]i+3 [4]i-3 [3]i+2 [2]i-2 [1]i+1 [0]i-1
  logic [5:0] MASKS [16] = '{6'b101010, 6'b101011, 6'b101111, 6'b111111,
                             6'b111111, 6'b111111, 6'b111111, 6'b111111,
                             6'b111111, 6'b111111, 6'b111111, 6'b111111,
                             6'b111111, 6'b011111, 6'b010111, 6'b010101};

  // Per-sweep data model: delta applied to every row of sweep s
  int   dtab [64];
  logic xtr  [64];
  int   c0 = 0;
  int   m_off, m_s;
  always_comb begin
    m_off = cyc - c0 - 16;
    m_s   = (m_off < 0) ? 0 : m_off / 17;
    if (m_s > 63) m_s = 63;
    x_old = 32'h0003_2000 + 32'(cyc * 7);
    x_new = x_old + 32'(dtab[m_s]);
    if (xtr[m_s]) begin
      x_new = 32'h7FFF_FFFF;
      x_old = 32'h8000_0000;
    end
  end

  typedef struct { int cyc; int a; int b; int c; } ev_t;
  ev_t q_b[$], q_row[$], q_x[$], q_out[$], q_err[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, req, cyc);
  endtask

  task automatic bad(input string nm, input int at);
    n_chk++;
    $display("FAIL %s: beat presence wrong, expected-at %0d, now cycle %0d", nm, at, cyc);
  endtask

  function automatic ev_t mk(input int cy, input int a, input int b, input int c);
    ev_t e;
    e.cyc = cy; e.a = a; e.b = b; e.c = c;
    return e;
  endfunction

  // Monitor: pops on every presented beat, flags beats that never came
  always @(negedge clk) begin : mon
    ev_t e;
    if (!reset) begin
      if (b_we) begin
        if (q_b.size() == 0) bad("b_we_unexpected", -1);
        else begin
          e = q_b.pop_front();
          chk("b_cycle", cyc, e.cyc); chk("b_waddr", b_waddr, e.a); chk("x_clr", x_clr, e.b);
        end
      end else begin
        if (x_clr) bad("x_clr_unexpected", -1);
        if (q_b.size() > 0 && q_b[0].cyc <= cyc) begin e = q_b.pop_front(); bad("b_we_missing", e.cyc); end
      end
      if (row_vld) begin
        if (q_row.size() == 0) bad("row_vld_unexpected", -1);
        else begin
          e = q_row.pop_front();
          chk("row_cycle", cyc, e.cyc); chk("row_idx", row_idx, e.a);
          chk("nb_mask", nb_mask, e.b); chk("fwd_m1", fwd_m1, e.c);
        end
      end else if (q_row.size() > 0 && q_row[0].cyc <= cyc) begin
        e = q_row.pop_front(); bad("row_vld_missing", e.cyc);
      end
      if (x_we) begin
        if (q_x.size() == 0) bad("x_we_unexpected", -1);
        else begin
          e = q_x.pop_front();
          chk("x_cycle", cyc, e.cyc); chk("x_waddr", x_waddr, e.a);
        end
      end else if (q_x.size() > 0 && q_x[0].cyc <= cyc) begin
        e = q_x.pop_front(); bad("x_we_missing", e.cyc);
      end
      if (out_valid) begin
        if (q_out.size() == 0) bad("out_valid_unexpected", -1);
        else begin
          e = q_out.pop_front();
          chk("out_cycle", cyc, e.cyc); chk("out_idx", out_idx, e.a);
          chk("out_iter_cnt", iter_cnt, e.b); chk("out_converged", converged, e.c);
        end
      end else if (q_out.size() > 0 && q_out[0].cyc <= cyc) begin
        e = q_out.pop_front(); bad("out_valid_missing", e.cyc);
      end
      if (load_err) begin
        if (q_err.size() == 0) bad("load_err_unexpected", -1);
        else begin e = q_err.pop_front(); chk("load_err_cycle", cyc, e.cyc); end
      end else if (q_err.size() > 0 && q_err[0].cyc <= cyc) begin
        e = q_err.pop_front(); bad("load_err_missing", e.cyc);
      end
    end
  end

  // Expected schedule for a full load starting at cycle c0 and S sweeps
  task automatic push_solve(input int S, input int conv);
    for (int k = 0; k < 16; k++) q_b.push_back(mk(c0 + k, k, (k == 0) ? 1 : 0, 0));
    for (int s = 0; s < S; s++) begin
      for (int r = 0; r < 16; r++) begin
        q_row.push_back(mk(c0 + 16 + 17 * s + r, r, int'(MASKS[r]), (r != 0) ? 1 : 0));
        q_x.push_back(mk(c0 + 17 + 17 * s + r, r, 0, 0));
      end
    end
    for (int k = 0; k < 16; k++) q_out.push_back(mk(c0 + 16 + 17 * S + k, k, S, conv));
  endtask

  // Called at posedge+1; returns at posedge+1 of the first IDLE cycle after output
  task automatic run_solve(input int S, input int conv, input int poke);
    c0 = cyc;
    push_solve(S, conv);
    in_en = 1'b1;
    repeat (16) begin @(posedge clk); #1; end
    in_en = 1'b0;
    while (cyc < c0 + 16 + 17 * S + 16) begin
      @(posedge clk); #1;
      in_en = (poke >= 0 && cyc == c0 + 16 + poke);
    end
    in_en = 1'b0;
    chk("busy_after_output", busy, 0);
    chk("iter_cnt_hold", iter_cnt, S);
    chk("converged_hold", converged, conv);
  endtask

  task automatic set_delta(input int d);
    for (int i = 0; i < 64; i++) begin dtab[i] = d; xtr[i] = 1'b0; end
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {b_we, b_waddr, x_clr, row_vld, row_idx, nb_mask, fwd_m1, x_we, x_waddr,
             out_valid, out_idx, iter_cnt, converged, load_err, busy}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    in_en = 1'b0;
    set_delta(0);
    #12;
    chk_all_zero("reset_outputs");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Converges on sweep 3; in_en poke mid-ITER must not write b
    set_delta(0);
    dtab[0] = 1000; dtab[1] = 1000;
    run_solve(3, 1, 20);

    // Load starts in the very IDLE cycle after output; |delta|=1000 never converges
    set_delta(1000);
    run_solve(50, 0, -1);

    // |delta| exactly TOL fails the strict comparison
    set_delta(16);
    run_solve(50, 0, -1);

    // Negative delta just under TOL converges on the first sweep
    set_delta(-15);
    run_solve(1, 1, -1);

    // Extreme operands: true 33-bit delta is huge, sweep 0 must fail
    set_delta(0);
    xtr[0] = 1'b1;
    run_solve(2, 1, -1);
    xtr[0] = 1'b0;

    // Short load: 7 beats then drop
    @(posedge clk); #1;
    c0 = cyc;
    for (int k = 0; k < 7; k++) q_b.push_back(mk(c0 + k, k, (k == 0) ? 1 : 0, 0));
    q_err.push_back(mk(c0 + 7, 0, 0, 0));
    in_en = 1'b1;
    repeat (7) begin @(posedge clk); #1; end
    in_en = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("busy_after_short_load", busy, 0);

    // Reset at row 8 of sweep 2, then a fresh load
    set_delta(1000);
    c0 = cyc;
    push_solve(50, 0);
    in_en = 1'b1;
    repeat (16) begin @(posedge clk); #1; end
    in_en = 1'b0;
    while (cyc < c0 + 16 + 17 + 8) begin @(posedge clk); #1; end
    chk("row_before_reset", row_idx, 8);
    #1 reset = 1'b1;
    #1 chk_all_zero("midsweep_reset_outputs");
    q_b.delete(); q_row.delete(); q_x.delete(); q_out.delete(); q_err.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    set_delta(0);
    run_solve(1, 1, -1);

    repeat (3) begin @(posedge clk); #1; end
    chk("scoreboard_drained", q_b.size() + q_row.size() + q_x.size() + q_out.size() + q_err.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
